// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute FSM driving PC, IR, RF and data memory.
// Optional macro CTRL_SEQ_RETIRE_CNT_EN adds a saturating retired-instruction counter.
module control_sequencer #(
    parameter int unsigned DA_W = 8,
    parameter int unsigned RA_W = 4,
    localparam int unsigned IR_W = 4 + DA_W + RA_W
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic [IR_W-1:0] IR,
    input  logic            D_rdy,
    input  logic            Resume,
    output logic            PC_clr,
    output logic            IR_ld,
    output logic            PC_up,
    output logic            D_wr,
    output logic            RF_s,
    output logic            RF_W_en,
    output logic [DA_W-1:0] D_addr,
    output logic [RA_W-1:0] RF_Ra_addr,
    output logic [RA_W-1:0] RF_Rb_addr,
    output logic [RA_W-1:0] RF_W_addr,
    output logic [2:0]      Alu_s0,
    output logic            Halted,
    output logic            Illegal,
    output logic [15:0]     Retired_cnt
);

    localparam int unsigned B = DA_W + RA_W;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_STORE  = 4'd4,
        S_LOAD_A = 4'd5,
        S_LOAD_B = 4'd6,
        S_ALU    = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] opcode;
    logic       illegal_set;
    logic       illegal_q;

    assign opcode = IR[IR_W-1:B];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= S_INIT;
        else          state <= state_nx;
    end

    // Next state and Moore/Mealy outputs from state and IR fields
    always_comb begin
        state_nx    = S_INIT;
        PC_clr      = 1'b0;
        IR_ld       = 1'b0;
        PC_up       = 1'b0;
        D_wr        = 1'b0;
        RF_s        = 1'b0;
        RF_W_en     = 1'b0;
        D_addr      = '0;
        RF_Ra_addr  = '0;
        RF_Rb_addr  = '0;
        RF_W_addr   = '0;
        Alu_s0      = 3'd0;
        Halted      = 1'b0;
        illegal_set = 1'b0;
        case (state)
            S_INIT: begin
                PC_clr   = 1'b1;
                state_nx = S_FETCH;
            end
            S_FETCH: begin
                IR_ld    = 1'b1;
                PC_up    = 1'b1;
                state_nx = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    4'd0:                      state_nx = S_NOOP;
                    4'd1:                      state_nx = S_STORE;
                    4'd2:                      state_nx = S_LOAD_A;
                    4'd3, 4'd4, 4'd6, 4'd7, 4'd8: state_nx = S_ALU;
                    4'd5:                      state_nx = S_HALT;
                    default: begin
                        state_nx    = S_NOOP;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            S_NOOP: state_nx = S_FETCH;
            S_STORE: begin
                D_addr     = IR[DA_W-1:0];
                D_wr       = 1'b1;
                RF_Ra_addr = IR[B-1 -: RA_W];
                state_nx   = D_rdy ? S_FETCH : S_STORE;
            end
            S_LOAD_A, S_LOAD_B: begin
                D_addr    = IR[B-1:RA_W];
                RF_s      = 1'b1;
                RF_W_addr = IR[RA_W-1:0];
                RF_W_en   = (state == S_LOAD_B);
                if (state == S_LOAD_B) state_nx = S_FETCH;
                else                   state_nx = D_rdy ? S_LOAD_B : S_LOAD_A;
            end
            S_ALU: begin
                RF_Ra_addr = IR[B-1 -: RA_W];
                RF_Rb_addr = IR[B-RA_W-1 -: RA_W];
                RF_W_addr  = IR[RA_W-1:0];
                RF_W_en    = 1'b1;
                case (opcode)
                    4'd3:    Alu_s0 = 3'd1;
                    4'd4:    Alu_s0 = 3'd2;
                    4'd6:    Alu_s0 = 3'd3;
                    4'd7:    Alu_s0 = 3'd4;
                    4'd8:    Alu_s0 = 3'd5;
                    default: Alu_s0 = 3'd0;
                endcase
                state_nx = S_FETCH;
            end
            S_HALT: begin
                Halted   = 1'b1;
                state_nx = Resume ? S_FETCH : S_HALT;
            end
            default: state_nx = S_INIT;
        endcase
    end

    // Sticky illegal-opcode flag, cleared only by reset
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)         illegal_q <= 1'b0;
        else if (illegal_set) illegal_q <= 1'b1;
    end

    assign Illegal = illegal_q;

`ifdef CTRL_SEQ_RETIRE_CNT_EN
    logic        retire;
    logic [15:0] retired_q;

    assign retire = (state == S_NOOP) || (state == S_LOAD_B) || (state == S_ALU)
                  || ((state == S_STORE) && D_rdy)
                  || ((state == S_DECODE) && (state_nx == S_HALT));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)                            retired_q <= 16'h0000;
        else if (retire && retired_q != 16'hFFFF) retired_q <= retired_q + 16'd1;
    end

    assign Retired_cnt = retired_q;
`else
    assign Retired_cnt = 16'h0000;
`endif

endmodule
